// File: rtl/pe_conv_ctrl_if.sv
// -----------------------------------------------------------------------------
// pe_conv_ctrl_if
//   Valid/ready stream bundle between the tile buffers and the PE-array
//   sequencer: one channel for kernel weights, one for image activations.
//
//   Signals
//     wt_valid   weight source has a weight available
//     wt_ready   sequencer accepts a weight this cycle
//     act_valid  activation source has a pixel available
//     act_ready  sequencer accepts a pixel this cycle
//
//   Modports
//     master  tile-buffer side (drives valid, observes ready)
//     slave   sequencer side   (observes valid, drives ready)
// -----------------------------------------------------------------------------
interface pe_conv_ctrl_if;
  logic wt_valid;
  logic wt_ready;
  logic act_valid;
  logic act_ready;

  modport master (
    output wt_valid,
    input  wt_ready,
    output act_valid,
    input  act_ready
  );

  modport slave (
    input  wt_valid,
    output wt_ready,
    input  act_valid,
    output act_ready
  );
endinterface

// File: rtl/pe_conv_ctrl.sv
// -----------------------------------------------------------------------------
// pe_conv_ctrl
//   Sequencer for a K x K array of PE_conv cells computing one convolution
//   tile. Loads K*K weights in raster order over the weight stream, then
//   streams img_w x img_h activations, driving the PE control strobes and
//   tagging each Psum with its output coordinate.
//
//   Ports
//     clk, rst                 clock (rising edge), async active-high reset
//     start                    begins a tile when idle (ignored otherwise)
//     abort                    synchronous abort back to idle, no done pulse
//     cfg_img_w, cfg_img_h     image dimensions, latched on accepted start
//     stream (slave)           weight / activation valid-ready handshakes
//     load_weight [K*K]        one-hot weight load strobe, bit i -> PE i
//     load_act                 broadcast activation load strobe
//     VF_store_ctrl            vertical-reuse buffer store enable
//     pe_enable                PE compute enable (Psum valid next edge)
//     psum_valid               PE Psum outputs valid this cycle
//     out_row, out_col         output coordinate of the current Psum
//     busy                     high in every state except idle
//     done                     one-cycle pulse at tile end
//     err                      sticky bad-config flag, cleared by next start
// -----------------------------------------------------------------------------
module pe_conv_ctrl #(
  parameter int K         = 3,
  parameter int DIM_BW    = 8,
  parameter int WT_IDX_BW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [DIM_BW-1:0]   cfg_img_w,
  input  logic [DIM_BW-1:0]   cfg_img_h,
  pe_conv_ctrl_if.slave       stream,
  output logic [K*K-1:0]      load_weight,
  output logic                load_act,
  output logic                VF_store_ctrl,
  output logic                pe_enable,
  output logic                psum_valid,
  output logic [DIM_BW-1:0]   out_row,
  output logic [DIM_BW-1:0]   out_col,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int                   KK      = K * K;
  localparam logic [WT_IDX_BW-1:0] WT_LAST = WT_IDX_BW'(KK - 1);
  localparam logic [WT_IDX_BW-1:0] WT_ONE  = WT_IDX_BW'(1);
  localparam logic [DIM_BW-1:0]    K_DIM   = DIM_BW'(K);
  localparam logic [DIM_BW-1:0]    K_M1    = DIM_BW'(K - 1);
  localparam logic [DIM_BW-1:0]    DIM_ONE = DIM_BW'(1);
  localparam logic [KK-1:0]        ONE_LSB = KK'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_WT = 3'd1,
    S_STREAM  = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;

  logic [WT_IDX_BW-1:0] wt_cnt_r;
  logic [DIM_BW-1:0]    row_r;
  logic [DIM_BW-1:0]    col_r;
  logic [DIM_BW-1:0]    img_w_r;
  logic [DIM_BW-1:0]    img_h_r;
  logic                 err_r;
  logic                 drain_cnt_r;

  // Two-stage Psum tag pipeline: stage 1 mirrors pe_enable, stage 2 psum_valid.
  logic                 pe_en_r;
  logic [DIM_BW-1:0]    st_row_r;
  logic [DIM_BW-1:0]    st_col_r;
  logic                 psum_valid_r;
  logic [DIM_BW-1:0]    out_row_r;
  logic [DIM_BW-1:0]    out_col_r;

  logic                 start_ok_s;
  logic                 cfg_bad_s;
  logic                 abort_s;
  logic                 last_wt_s;
  logic                 last_col_s;
  logic                 last_row_s;
  logic                 last_px_s;
  logic                 win_valid_s;
  logic                 wt_hs_s;
  logic                 act_hs_s;

  logic                 wt_ready_s;
  logic                 act_ready_s;
  logic [KK-1:0]        load_weight_s;
  logic                 load_act_s;
  logic                 vf_s;
  logic                 done_s;

  assign start_ok_s  = start && (state_r == S_IDLE);
  assign cfg_bad_s   = (cfg_img_w < K_DIM) || (cfg_img_h < K_DIM);
  assign abort_s     = abort && (state_r != S_IDLE);
  assign last_wt_s   = (wt_cnt_r == WT_LAST);
  assign last_col_s  = (col_r == (img_w_r - DIM_ONE));
  assign last_row_s  = (row_r == (img_h_r - DIM_ONE));
  assign last_px_s   = last_col_s && last_row_s;
  // Window is complete once K-1 rows and K-1 columns precede the pixel.
  assign win_valid_s = (row_r >= K_M1) && (col_r >= K_M1);
  assign wt_hs_s     = wt_ready_s && stream.wt_valid;
  assign act_hs_s    = act_ready_s && stream.act_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and handshake-driven strobes; abort suppresses every load.
  always_comb begin
    state_nxt_s   = state_r;
    wt_ready_s    = 1'b0;
    act_ready_s   = 1'b0;
    load_weight_s = '0;
    load_act_s    = 1'b0;
    vf_s          = 1'b0;
    done_s        = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad_s) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_LOAD_WT;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LOAD_WT: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else begin
          wt_ready_s = 1'b1;
          if (stream.wt_valid) begin
            load_weight_s = ONE_LSB << wt_cnt_r;
            if (last_wt_s) begin
              state_nxt_s = S_STREAM;
            end else begin
              state_nxt_s = S_LOAD_WT;
            end
          end else begin
            state_nxt_s = S_LOAD_WT;
          end
        end
      end
      S_STREAM: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else begin
          act_ready_s = 1'b1;
          if (stream.act_valid) begin
            load_act_s = 1'b1;
            // The bottom image row is never reused vertically.
            vf_s       = !last_row_s;
            if (last_px_s) begin
              state_nxt_s = S_DRAIN;
            end else begin
              state_nxt_s = S_STREAM;
            end
          end else begin
            state_nxt_s = S_STREAM;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else if (drain_cnt_r) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      S_DONE: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else begin
          done_s      = 1'b1;
          state_nxt_s = S_IDLE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Config latch, sticky error and weight/pixel position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_w_r  <= '0;
      img_h_r  <= '0;
      err_r    <= 1'b0;
      wt_cnt_r <= '0;
      row_r    <= '0;
      col_r    <= '0;
    end else if (abort_s) begin
      wt_cnt_r <= '0;
      row_r    <= '0;
      col_r    <= '0;
    end else if (start_ok_s) begin
      img_w_r  <= cfg_img_w;
      img_h_r  <= cfg_img_h;
      err_r    <= cfg_bad_s;
      wt_cnt_r <= '0;
      row_r    <= '0;
      col_r    <= '0;
    end else if (wt_hs_s) begin
      if (last_wt_s) begin
        wt_cnt_r <= '0;
        row_r    <= '0;
        col_r    <= '0;
      end else begin
        wt_cnt_r <= wt_cnt_r + WT_ONE;
      end
    end else if (act_hs_s) begin
      if (last_col_s) begin
        col_r <= '0;
        row_r <= row_r + DIM_ONE;
      end else begin
        col_r <= col_r + DIM_ONE;
      end
    end
  end

  // Two-cycle flush counter, restarted whenever DRAIN is not the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt_r <= 1'b0;
    end else if (state_r == S_DRAIN) begin
      drain_cnt_r <= !drain_cnt_r;
    end else begin
      drain_cnt_r <= 1'b0;
    end
  end

  // Psum tag pipeline: accepted pixel with a full window -> enable -> valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_en_r      <= 1'b0;
      st_row_r     <= '0;
      st_col_r     <= '0;
      psum_valid_r <= 1'b0;
      out_row_r    <= '0;
      out_col_r    <= '0;
    end else if (abort_s) begin
      pe_en_r      <= 1'b0;
      st_row_r     <= '0;
      st_col_r     <= '0;
      psum_valid_r <= 1'b0;
      out_row_r    <= '0;
      out_col_r    <= '0;
    end else begin
      pe_en_r      <= act_hs_s && win_valid_s;
      psum_valid_r <= pe_en_r;
      if (act_hs_s && win_valid_s) begin
        // Output coordinate is the top-left corner of the window.
        st_row_r <= row_r - K_M1;
        st_col_r <= col_r - K_M1;
      end
      if (pe_en_r) begin
        out_row_r <= st_row_r;
        out_col_r <= st_col_r;
      end
    end
  end

  assign stream.wt_ready  = wt_ready_s;
  assign stream.act_ready = act_ready_s;
  assign load_weight      = load_weight_s;
  assign load_act         = load_act_s;
  assign VF_store_ctrl    = vf_s;
  assign pe_enable        = pe_en_r;
  assign psum_valid       = psum_valid_r;
  assign out_row          = out_row_r;
  assign out_col          = out_col_r;
  assign busy             = (state_r != S_IDLE);
  assign done             = done_s;
  assign err              = err_r;

endmodule

// File: tb/tb_pe_conv_ctrl.sv
module tb_pe_conv_ctrl;
  localparam int K  = 3;
  localparam int KK = K * K;

  typedef struct {
    logic [7:0] row;
    logic [7:0] col;
  } coord_t;

  typedef struct {
    logic err;
    logic timed;
  } done_exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    cfg_img_w = 8'd0;
  logic [7:0]    cfg_img_h = 8'd0;
  logic [KK-1:0] load_weight;
  logic          load_act;
  logic          VF_store_ctrl;
  logic          pe_enable;
  logic          psum_valid;
  logic [7:0]    out_row;
  logic [7:0]    out_col;
  logic          busy;
  logic          done;
  logic          err;

  pe_conv_ctrl_if stream_if ();

  pe_conv_ctrl #(.K(3), .DIM_BW(8), .WT_IDX_BW(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .cfg_img_w    (cfg_img_w),
    .cfg_img_h    (cfg_img_h),
    .stream       (stream_if),
    .load_weight  (load_weight),
    .load_act     (load_act),
    .VF_store_ctrl(VF_store_ctrl),
    .pe_enable    (pe_enable),
    .psum_valid   (psum_valid),
    .out_row      (out_row),
    .out_col      (out_col),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  logic [KK-1:0] wt_q[$];
  coord_t        psum_q[$];
  done_exp_t     done_q[$];

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  act_cnt = 0;
  int  vf_cnt = 0;
  int  wt_hs = 0;
  int  done_seen = 0;
  int  last_hs_cyc = 0;
  bit  rand_act = 1'b0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, pops expectations.
  initial begin
    logic [KK-1:0] wexp;
    coord_t        cexp;
    done_exp_t     dexp;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        cyc++;
        if (load_weight != '0) begin
          wt_hs++;
          check("wt_act_overlap", {31'd0, load_act}, 32'd0);
          check("wt_expected", {31'd0, wt_q.size() != 0}, 32'd1);
          if (wt_q.size() != 0) begin
            wexp = wt_q.pop_front();
            check("load_weight", 32'(load_weight), 32'(wexp));
          end
        end
        if (VF_store_ctrl) begin
          check("vf_without_act", {31'd0, load_act}, 32'd1);
        end
        if (load_act) begin
          act_cnt++;
          last_hs_cyc = cyc;
          if (VF_store_ctrl) vf_cnt++;
        end
        if (psum_valid) begin
          check("psum_expected", {31'd0, psum_q.size() != 0}, 32'd1);
          if (psum_q.size() != 0) begin
            cexp = psum_q.pop_front();
            check("out_row", 32'(out_row), 32'(cexp.row));
            check("out_col", 32'(out_col), 32'(cexp.col));
          end
        end
        if (done) begin
          done_seen++;
          check("done_expected", {31'd0, done_q.size() != 0}, 32'd1);
          if (done_q.size() != 0) begin
            dexp = done_q.pop_front();
            check("done_err", {31'd0, err}, {31'd0, dexp.err});
            if (dexp.timed) begin
              check("done_latency", 32'(cyc - last_hs_cyc), 32'd3);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tile(int w, int h);
    logic [KK-1:0] one;
    coord_t c;
    one = {{(KK-1){1'b0}}, 1'b1};
    for (int i = 0; i < KK; i++) wt_q.push_back(one << i);
    for (int r = 0; r <= h - K; r++) begin
      for (int cc = 0; cc <= w - K; cc++) begin
        c.row = 8'(r);
        c.col = 8'(cc);
        psum_q.push_back(c);
      end
    end
    done_q.push_back('{err: 1'b0, timed: 1'b1});
  endtask

  task automatic do_start(int w, int h);
    cfg_img_w = 8'(w);
    cfg_img_h = 8'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(int max_cyc);
    int seen0;
    bit got;
    seen0 = done_seen;
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      stream_if.act_valid = rand_act ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (done_seen != seen0) got = 1'b1;
    end
    stream_if.act_valid = 1'b1;
    check("done_reached", {31'd0, got}, 32'd1);
  endtask

  task automatic check_queues(string tag);
    check({tag, "_wt_q_empty"}, 32'(wt_q.size()), 32'd0);
    check({tag, "_psum_q_empty"}, 32'(psum_q.size()), 32'd0);
    check({tag, "_done_q_empty"}, 32'(done_q.size()), 32'd0);
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_load_weight"}, 32'(load_weight), 32'd0);
    check({tag, "_load_act"}, {31'd0, load_act}, 32'd0);
    check({tag, "_pe_enable"}, {31'd0, pe_enable}, 32'd0);
    check({tag, "_psum_valid"}, {31'd0, psum_valid}, 32'd0);
    check({tag, "_wt_ready"}, {31'd0, stream_if.wt_ready}, 32'd0);
    check({tag, "_act_ready"}, {31'd0, stream_if.act_ready}, 32'd0);
  endtask

  initial begin
    int base_act;
    int base_vf;
    int base_wt;
    bit found;
    stream_if.wt_valid  = 1'b0;
    stream_if.act_valid = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_out_row", 32'(out_row), 32'd0);
    check("reset_out_col", 32'(out_col), 32'd0);
    tick();
    rst = 1'b0;
    stream_if.wt_valid  = 1'b1;
    stream_if.act_valid = 1'b1;
    tick();

    // 5x5 tile, sources always valid.
    base_act = act_cnt;
    base_vf  = vf_cnt;
    push_tile(5, 5);
    do_start(5, 5);
    @(negedge clk);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_wt_ready", {31'd0, stream_if.wt_ready}, 32'd1);
    run_to_done(200);
    @(negedge clk);
    check("t1_idle_busy", {31'd0, busy}, 32'd0);
    check("t1_act_count", 32'(act_cnt - base_act), 32'd25);
    check("t1_vf_count", 32'(vf_cnt - base_vf), 32'd20);
    check_queues("t1");

    // Width below K: straight to done with err.
    tick();
    done_q.push_back('{err: 1'b1, timed: 1'b0});
    do_start(2, 5);
    @(negedge clk);
    check("bad_done", {31'd0, done}, 32'd1);
    check("bad_wt_ready", {31'd0, stream_if.wt_ready}, 32'd0);
    check("bad_err", {31'd0, err}, 32'd1);
    tick();
    @(negedge clk);
    check("bad_idle_busy", {31'd0, busy}, 32'd0);
    check("bad_err_sticky", {31'd0, err}, 32'd1);
    check_queues("bad");

    // 5x5 tile with random activation bubbles; start clears err.
    tick();
    base_act = act_cnt;
    base_vf  = vf_cnt;
    push_tile(5, 5);
    do_start(5, 5);
    @(negedge clk);
    check("rand_err_cleared", {31'd0, err}, 32'd0);
    rand_act = 1'b1;
    run_to_done(400);
    rand_act = 1'b0;
    @(negedge clk);
    check("rand_act_count", 32'(act_cnt - base_act), 32'd25);
    check("rand_vf_count", 32'(vf_cnt - base_vf), 32'd20);
    check_queues("rand");

    // Abort when pixel 12 is presented.
    tick();
    for (int i = 0; i < KK; i++) wt_q.push_back(KK'(1) << i);
    do_start(5, 5);
    base_act = act_cnt;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (act_cnt - base_act == 12) found = 1'b1;
      else tick();
    end
    check("abort_reached_px12", {31'd0, found}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    check("abort_no_load", {31'd0, load_act}, 32'd0);
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle_busy", {31'd0, busy}, 32'd0);
    check("abort_psum_valid", {31'd0, psum_valid}, 32'd0);
    check("abort_pe_enable", {31'd0, pe_enable}, 32'd0);
    repeat (10) tick();
    check("abort_act_count", 32'(act_cnt - base_act), 32'd12);
    check_queues("abort");

    // Reset pulse in the middle of weight loading.
    push_tile(5, 5);
    do_start(5, 5);
    base_wt = wt_hs;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (wt_hs - base_wt == 4) found = 1'b1;
      else tick();
    end
    check("rst_reached_wt4", {31'd0, found}, 32'd1);
    rst = 1'b1;
    #1;
    check_quiet("midrst");
    check("midrst_err", {31'd0, err}, 32'd0);
    wt_q.delete();
    psum_q.delete();
    done_q.delete();
    tick();
    rst = 1'b0;
    tick();
    base_act = act_cnt;
    push_tile(5, 5);
    do_start(5, 5);
    run_to_done(200);
    check("post_rst_act_count", 32'(act_cnt - base_act), 32'd25);
    check_queues("post_rst");

    // Start while busy with a new config is ignored (6x4 tile runs).
    tick();
    base_act = act_cnt;
    base_vf  = vf_cnt;
    push_tile(6, 4);
    do_start(6, 4);
    repeat (14) tick();
    check("busy_during_restart", {31'd0, busy}, 32'd1);
    do_start(7, 7);
    run_to_done(200);
    @(negedge clk);
    check("restart_act_count", 32'(act_cnt - base_act), 32'd24);
    check("restart_vf_count", 32'(vf_cnt - base_vf), 32'd18);
    check("restart_idle_busy", {31'd0, busy}, 32'd0);
    check_queues("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
